// File: rtl/spi_reg_master_pkg.sv
// Shared definitions for the SPI register-access initiator.
// Contents:
//   state_e     - FSM state encoding, also exported on the debug port
//   DEF_*       - default parameter values shared by the interface and top
//   frame_bits  - total serial frame length (address + dummy + data)
package spi_reg_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_SHIFT_HI = 3'd2,
    ST_SHIFT_LO = 3'd3,
    ST_HOLD     = 3'd4,
    ST_GAP      = 3'd5
  } state_e;

  localparam int DEF_ADDR_W       = 8;   // includes the R/W bit at ADDR_W-1
  localparam int DEF_DATA_W       = 16;
  localparam int DEF_DUMMY_CYCLES = 8;
  localparam int DEF_CLK_DIV      = 4;
  localparam int DEF_CS_GAP       = 2;

  function automatic int frame_bits(input int addr_w, input int dummy, input int data_w);
    return addr_w + dummy + data_w;
  endfunction

endpackage

// File: rtl/spi_reg_master_if.sv
// Command/response port of the SPI register initiator.
// Signals:
//   cmd_valid/cmd_ready - request handshake
//   cmd_we/addr/wdata   - command payload (addr excludes the R/W bit)
//   rsp_valid/rsp_rdata - one-cycle completion pulse and captured read data
//   busy                - frame or inter-frame gap in progress
// Handshake: a command transfers on a cycle where cmd_valid and cmd_ready are
// both high; the payload is sampled only on that cycle. cmd_ready depends only
// on the initiator's own state, never on cmd_valid. rsp_valid has no ready: it
// is a single-cycle pulse and rsp_rdata holds until the next pulse.
interface spi_reg_master_if
  import spi_reg_master_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-2:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;

  // Requester side
  modport master (output cmd_valid, cmd_we, cmd_addr, cmd_wdata,
                  input  cmd_ready, rsp_valid, rsp_rdata, busy);
  // Initiator side (the SPI engine)
  modport slave  (input  cmd_valid, cmd_we, cmd_addr, cmd_wdata,
                  output cmd_ready, rsp_valid, rsp_rdata, busy);
endinterface

// File: rtl/spi_reg_master_clk_div.sv
// Half-period tick generator for the SPI engine.
// Ports:
//   clk, rst - system clock, synchronous active-high reset
//   clr      - restart the half-period (used when a command is accepted)
//   tick     - high for one cycle every CLK_DIV cycles
module spi_reg_master_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("spi_reg_master_clk_div: CLK_DIV must be >= 1");
  end

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_reg_master.sv
// SPI mode-0 initiator for the board register protocol.
// Frame: {R/W(1=read), addr}, DUMMY_CYCLES zero bits, data; MSB first.
// Ports:
//   sys_clk, sys_rst - system clock, synchronous active-high reset
//   cmd              - command/response interface (slave modport)
//   spi_clk/mosi/cs_n, spi_miso - SPI pins; SCK idles low
//   dbg_state        - current FSM state
module spi_reg_master
  import spi_reg_master_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int DUMMY_CYCLES = DEF_DUMMY_CYCLES,
  parameter int CLK_DIV      = DEF_CLK_DIV,
  parameter int CS_GAP       = DEF_CS_GAP
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  spi_reg_master_if.slave cmd,
  output logic            spi_clk,
  output logic            spi_mosi,
  input  logic            spi_miso,
  output logic            spi_cs_n,
  output state_e          dbg_state
);

  localparam int NBITS      = frame_bits(ADDR_W, DUMMY_CYCLES, DATA_W);
  localparam int DATA_START = ADDR_W + DUMMY_CYCLES;
  localparam int BW         = $clog2(NBITS);
  localparam int GW         = $clog2(CS_GAP + 2);
  localparam logic [BW-1:0] LAST_BIT   = BW'(NBITS - 1);
  localparam logic [BW-1:0] FIRST_DATA = BW'(DATA_START);
  localparam logic [GW-1:0] GAP_LOAD   = (CS_GAP > 0) ? GW'(CS_GAP - 1) : '0;

  state_e            state_q, state_d;
  logic [NBITS-1:0]  shreg_q, shreg_d;
  logic [DATA_W-1:0] cap_q, cap_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              sclk_q, sclk_d;
  logic              cs_n_q, cs_n_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              tick, accept, gap_zero;

  spi_reg_master_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk  (sys_clk),
    .rst  (sys_rst),
    .clr  (accept),
    .tick (tick)
  );

  assign cmd.cmd_ready = (state_q == ST_IDLE) && !sys_rst;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign gap_zero      = (gap_q == '0);

  // State register and datapath flops
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      cap_q       <= '0;
      rdata_q     <= '0;
      bit_q       <= '0;
      gap_q       <= '0;
      sclk_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cap_q       <= cap_d;
      rdata_q     <= rdata_d;
      bit_q       <= bit_d;
      gap_q       <= gap_d;
      sclk_q      <= sclk_d;
      cs_n_q      <= cs_n_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (accept) state_d = ST_SETUP;
      ST_SETUP:    if (tick) state_d = ST_SHIFT_HI;
      ST_SHIFT_HI: if (tick) state_d = (bit_q == LAST_BIT) ? ST_HOLD : ST_SHIFT_LO;
      ST_SHIFT_LO: if (tick) state_d = ST_SHIFT_HI;
      ST_HOLD:     if (tick && gap_zero) state_d = (CS_GAP == 0) ? ST_IDLE : ST_GAP;
      ST_GAP:      if (tick && gap_zero) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Datapath / pin updates. MOSI is the shift register MSB: the frame is
  // shifted once per SCK fall, so after the last bit it has drained to zero.
  always_comb begin
    shreg_d     = shreg_q;
    cap_d       = cap_q;
    rdata_d     = rdata_q;
    bit_d       = bit_q;
    gap_d       = gap_q;
    sclk_d      = sclk_q;
    cs_n_d      = cs_n_q;
    rsp_valid_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shreg_d = (NBITS'({~cmd.cmd_we, cmd.cmd_addr}) << (NBITS - ADDR_W))
                  | NBITS'(cmd.cmd_wdata);
          bit_d   = '0;
          cs_n_d  = 1'b0;
        end
      end
      ST_SETUP, ST_SHIFT_LO: begin
        if (tick) sclk_d = 1'b1;
      end
      ST_SHIFT_HI: begin
        if (tick) begin
          sclk_d  = 1'b0;
          shreg_d = shreg_q << 1;
          bit_d   = bit_q + 1'b1;
          if (bit_q >= FIRST_DATA) cap_d = {cap_q[DATA_W-2:0], spi_miso};
          // HOLD spans two half-periods: gap_q counts the remaining one.
          if (bit_q == LAST_BIT) gap_d = GW'(1);
        end
      end
      ST_HOLD: begin
        if (tick) begin
          if (!gap_zero) begin
            gap_d = gap_q - 1'b1;
          end else begin
            cs_n_d      = 1'b1;
            rsp_valid_d = 1'b1;
            rdata_d     = cap_q;
            gap_d       = GAP_LOAD;
          end
        end
      end
      ST_GAP: begin
        if (tick && !gap_zero) gap_d = gap_q - 1'b1;
      end
      default: ;
    endcase
  end

  assign spi_clk       = sclk_q;
  assign spi_mosi      = shreg_q[NBITS-1];
  assign spi_cs_n      = cs_n_q;
  assign cmd.rsp_valid = rsp_valid_q;
  assign cmd.rsp_rdata = rdata_q;
  assign cmd.busy      = (state_q != ST_IDLE);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_spi_reg_master.sv
// Directed bench for spi_reg_master: default instance (CLK_DIV=4, CS_GAP=2)
// plus a CLK_DIV=1 / CS_GAP=0 instance, each with a small SPI slave model.
module tb_spi_reg_master;
  import spi_reg_master_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 clk = ~clk;

  spi_reg_master_if c1();
  spi_reg_master_if c2();

  logic   sck1, mosi1, miso1, csn1;
  logic   sck2, mosi2, miso2, csn2;
  state_e st1, st2;

  spi_reg_master dut1 (
    .sys_clk(clk), .sys_rst(sys_rst), .cmd(c1),
    .spi_clk(sck1), .spi_mosi(mosi1), .spi_miso(miso1), .spi_cs_n(csn1),
    .dbg_state(st1)
  );

  spi_reg_master #(.CLK_DIV(1), .CS_GAP(0)) dut2 (
    .sys_clk(clk), .sys_rst(sys_rst), .cmd(c2),
    .spi_clk(sck2), .spi_mosi(mosi2), .spi_miso(miso2), .spi_cs_n(csn2),
    .dbg_state(st2)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // ---------------- slave model 1: 128 x 16 register file ----------------
  logic [31:0] s_rx;
  int          s_rises, s_falls;
  logic [15:0] s_tx;
  logic [15:0] s_mem [128];

  always @(negedge csn1) begin s_rises = 0; s_falls = 0; s_rx = '0; end
  always @(posedge sck1) begin
    s_rx = {s_rx[30:0], mosi1};
    s_rises++;
    if (s_rises == 8) s_tx = s_mem[s_rx[6:0]];
  end
  always @(negedge sck1) begin
    s_falls++;
    miso1 = (s_falls >= 16 && s_falls <= 31) ? s_tx[4'(31 - s_falls)] : 1'b0;
  end
  always @(posedge csn1) if (s_rises == 32 && !s_rx[31]) s_mem[s_rx[30:24]] = s_rx[15:0];

  // ---------------- slave model 2: fixed read word ----------------
  logic [31:0] s2_rx;
  int          s2_rises, s2_falls;
  logic [15:0] s2_word = 16'h2A2A;

  always @(negedge csn2) begin s2_rises = 0; s2_falls = 0; s2_rx = '0; end
  always @(posedge sck2) begin s2_rx = {s2_rx[30:0], mosi2}; s2_rises++; end
  always @(negedge sck2) begin
    s2_falls++;
    miso2 = (s2_falls >= 16 && s2_falls <= 31) ? s2_word[4'(31 - s2_falls)] : 1'b0;
  end

  // ---------------- instance select for the driver tasks ----------------
  logic use2 = 1'b0;
  wire        m_csn   = use2 ? csn2 : csn1;
  wire        m_sck   = use2 ? sck2 : sck1;
  wire        m_ready = use2 ? c2.cmd_ready : c1.cmd_ready;
  wire        m_rspv  = use2 ? c2.rsp_valid : c1.rsp_valid;
  wire [15:0] m_rdata = use2 ? c2.rsp_rdata : c1.rsp_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_cmd(input logic v, input logic we, input logic [6:0] a, input logic [15:0] d);
    if (use2) begin c2.cmd_valid = v; c2.cmd_we = we; c2.cmd_addr = a; c2.cmd_wdata = d; end
    else      begin c1.cmd_valid = v; c1.cmd_we = we; c1.cmd_addr = a; c1.cmd_wdata = d; end
  endtask

  // One command: accept, then scramble the payload to show it is sampled
  // only on accept; measure latency (accept cycle = 0), cs_n low cycles,
  // SCK rises, cmd_ready while cs_n low, and cmd_ready on the rsp cycle.
  task automatic xact(input logic we, input logic [6:0] a, input logic [15:0] d,
                      output logic [15:0] rd, output int cs_low, output int lat,
                      output int rises, output int rdy_low, output logic rdy_end);
    logic prev;
    int   n;
    @(negedge clk);
    drive_cmd(1'b1, we, a, d);
    for (int g = 0; g < 100; g++) begin
      if (m_ready) break;
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    drive_cmd(1'b0, ~we, ~a, ~d);
    cs_low = 0; rises = 0; rdy_low = 0; prev = 1'b0;
    for (n = 1; n < 2000; n++) begin
      if (!m_csn) begin cs_low++; if (m_ready) rdy_low++; end
      if (m_sck && !prev) rises++;
      prev = m_sck;
      if (m_rspv) break;
      @(negedge clk);
    end
    lat = n;
    rd = m_rdata;
    rdy_end = m_ready;
    @(negedge clk);
    chk("rsp_single_cycle", 32'(m_rspv), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [15:0] rd;
    logic [15:0] pats [6];
    int cs_low, lat, rises, rdy_low, cs_high, pulses, bad, g;
    logic rdy_end;

    pats[0] = 16'hAAAA; pats[1] = 16'h5555; pats[2] = 16'h0001;
    pats[3] = 16'h8000; pats[4] = 16'hFFFF; pats[5] = 16'h0000;
    for (int i = 0; i < 128; i++) s_mem[i] = '0;
    miso1 = 1'b0; miso2 = 1'b0;
    use2 = 1'b0;
    drive_cmd(1'b0, 1'b0, 7'h0, 16'h0);
    use2 = 1'b1;
    drive_cmd(1'b0, 1'b0, 7'h0, 16'h0);
    use2 = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_ready",   32'(c1.cmd_ready), 32'd0);
    chk("rst_cs_n",    32'(csn1),         32'd1);
    chk("rst_sck",     32'(sck1),         32'd0);
    chk("rst_mosi",    32'(mosi1),        32'd0);
    chk("rst_busy",    32'(c1.busy),      32'd0);
    chk("rst_rspv",    32'(c1.rsp_valid), 32'd0);
    chk("rst_rdata",   32'(c1.rsp_rdata), 32'd0);
    chk("rst_cs_n_2",  32'(csn2),         32'd1);
    sys_rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(c1.cmd_ready), 32'd1);

    // Write 0x00 <- 0xAAAA
    xact(1'b1, 7'h00, 16'hAAAA, rd, cs_low, lat, rises, rdy_low, rdy_end);
    chk("wr_cs_low_cycles", 32'(cs_low), 32'd264);
    chk("wr_latency",       32'(lat),    32'd265);
    chk("wr_sck_rises",     32'(rises),  32'd32);
    chk("wr_mosi_stream",   s_rx,        32'h0000AAAA);
    chk("wr_ready_in_frame",32'(rdy_low),32'd0);
    chk("wr_ready_at_rsp",  32'(rdy_end),32'd0);

    // Write/read pairs over data patterns
    for (int i = 0; i < 6; i++) begin
      xact(1'b1, 7'h00, pats[i], rd, cs_low, lat, rises, rdy_low, rdy_end);
      xact(1'b0, 7'h00, 16'h0000, rd, cs_low, lat, rises, rdy_low, rdy_end);
      chk("rd_data",      32'(rd),         32'(pats[i]));
      chk("rd_addr_byte", 32'(s_rx[31:24]),32'h80);
      chk("rd_latency",   32'(lat),        32'd265);
      repeat (20) @(negedge clk);
      chk("rd_data_held", 32'(c1.rsp_rdata), 32'(pats[i]));
    end

    // Back-to-back: cmd_valid stays high across two writes
    @(negedge clk);
    drive_cmd(1'b1, 1'b1, 7'h01, 16'h1357);
    for (g = 0; g < 100; g++) begin
      if (c1.cmd_ready) break;
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    drive_cmd(1'b1, 1'b1, 7'h02, 16'h2468);
    bad = 0; cs_high = 0; pulses = 0;
    for (g = 0; g < 2000; g++) begin
      if (c1.rsp_valid) pulses++;
      if (csn1) cs_high++;
      else if (cs_high > 0) break;
      else if (c1.cmd_ready) bad++;
      @(negedge clk);
    end
    drive_cmd(1'b0, 1'b0, 7'h00, 16'h0000);
    chk("b2b_ready_low_in_frame", 32'(bad),    32'd0);
    chk("b2b_one_rsp",            32'(pulses), 32'd1);
    chk("b2b_gap_ge_8",           32'(cs_high >= 8 && g < 2000), 32'd1);
    chk("b2b_first_write",        32'(s_mem[1]), 32'h1357);
    for (g = 0; g < 2000; g++) begin
      if (c1.rsp_valid) break;
      @(negedge clk);
    end
    chk("b2b_second_rsp_seen",    32'(g < 2000), 32'd1);
    chk("b2b_second_frame",       s_rx, 32'h02002468);
    chk("b2b_second_write",       32'(s_mem[2]), 32'h2468);

    // Read back something nonzero so the reset clear of rsp_rdata is visible
    xact(1'b0, 7'h02, 16'h0000, rd, cs_low, lat, rises, rdy_low, rdy_end);
    chk("pre_rst_rd", 32'(rd), 32'h2468);

    // Reset during bit 12 of a write
    @(negedge clk);
    drive_cmd(1'b1, 1'b1, 7'h03, 16'hBEEF);
    for (g = 0; g < 100; g++) begin
      if (c1.cmd_ready) break;
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    drive_cmd(1'b0, 1'b0, 7'h00, 16'h0000);
    for (g = 0; g < 2000; g++) begin
      if (s_rises >= 13) break;
      @(negedge clk);
    end
    chk("mid_rst_reached_bit12", 32'(s_rises), 32'd13);
    sys_rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_cs_n",  32'(csn1),         32'd1);
    chk("mid_rst_sck",   32'(sck1),         32'd0);
    chk("mid_rst_mosi",  32'(mosi1),        32'd0);
    chk("mid_rst_rdata", 32'(c1.rsp_rdata), 32'd0);
    chk("mid_rst_busy",  32'(c1.busy),      32'd0);
    sys_rst = 1'b0;
    pulses = 0;
    repeat (20) begin
      if (c1.rsp_valid) pulses++;
      @(negedge clk);
    end
    chk("mid_rst_no_rsp",    32'(pulses),   32'd0);
    chk("mid_rst_no_commit", 32'(s_mem[3]), 32'd0);
    xact(1'b1, 7'h03, 16'h1234, rd, cs_low, lat, rises, rdy_low, rdy_end);
    chk("post_rst_wr_frame", s_rx,          32'h03001234);
    chk("post_rst_wr_rises", 32'(rises),    32'd32);
    chk("post_rst_wr_cs",    32'(cs_low),   32'd264);
    xact(1'b0, 7'h03, 16'h0000, rd, cs_low, lat, rises, rdy_low, rdy_end);
    chk("post_rst_rd",       32'(rd),       32'h1234);

    // CLK_DIV=1, CS_GAP=0 instance: read 0x05
    use2 = 1'b1;
    xact(1'b0, 7'h05, 16'h0000, rd, cs_low, lat, rises, rdy_low, rdy_end);
    chk("div1_rd_data",       32'(rd),           32'h2A2A);
    chk("div1_cs_low_cycles", 32'(cs_low),       32'd66);
    chk("div1_latency",       32'(lat),          32'd67);
    chk("div1_sck_rises",     32'(rises),        32'd32);
    chk("div1_addr_byte",     32'(s2_rx[31:24]), 32'h85);
    chk("div1_ready_in_frame",32'(rdy_low),      32'd0);
    chk("div1_ready_at_rsp",  32'(rdy_end),      32'd1);
    chk("div1_ready_after",   32'(c2.cmd_ready), 32'd1);
    use2 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
